cfs_md_rx_responder: RTL and testbench

- Responder (slave) end of the MD data protocol (valid/data/offset/size/ready/err), clocked by pclk.
- Accepts MD transfers from an MD initiator and checks offset/size legality.
- Answers each transfer with a registered ready/err response.
- Unpacks the valid bytes of each legal transfer into an internal byte FIFO, drained as a one-byte-per-cycle output stream.
- Back-pressures the MD initiator by withholding ready while FIFO space is insufficient.

---
 rtl/cfs_md_rx_responder_if.sv | 14 +
 rtl/cfs_md_rx_responder.sv | 75 +++++++
 tb/tb_cfs_md_rx_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cfs_md_rx_responder_if.sv
// cfs_md_rx_responder_if: MD data-protocol bus between an initiator (master) and a responder (slave).
interface cfs_md_rx_responder_if #(parameter int DATA_WIDTH = 32);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFFSET_WIDTH = (NB > 1) ? $clog2(NB) : 1;
  localparam int SIZE_WIDTH = $clog2(NB) + 1;
  logic md_valid;
  logic [DATA_WIDTH-1:0] md_data;
  logic [OFFSET_WIDTH-1:0] md_offset;
  logic [SIZE_WIDTH-1:0] md_size;
  logic md_ready;
  logic md_err;
  modport master(output md_valid, md_data, md_offset, md_size, input md_ready, md_err);
  modport slave(input md_valid, md_data, md_offset, md_size, output md_ready, md_err);
endinterface

// File: rtl/cfs_md_rx_responder.sv
// cfs_md_rx_responder: MD responder that checks transfers and unpacks legal bytes into a show-ahead byte FIFO.
module cfs_md_rx_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 pclk,
  input  logic                 reset,
  cfs_md_rx_responder_if.slave md,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic [LVL_WIDTH-1:0] fill_level,
  output logic [7:0]           err_cnt
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SW1 = $clog2(NB) + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic ready_q, ready_d, err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_WIDTH-1:0] fill_q, fill_d, free;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [SW1-1:0] span;
  logic [DATA_WIDTH-1:0] shifted;
  logic legal, fits, push, pop;
  always_comb begin
    span = SW1'(md.md_offset) + SW1'(md.md_size);
    legal = (md.md_size != '0) && (span <= SW1'(NB));
    free = LVL_WIDTH'(FIFO_DEPTH) - fill_q;
    fits = free >= LVL_WIDTH'(md.md_size);
    push = (state_q == RESP) && ready_q && md.md_valid && !err_q;
    pop = (fill_q != '0) && out_ready;
    shifted = md.md_data >> {md.md_offset, 3'b000};
    state_d = (state_q == IDLE && md.md_valid && (!legal || fits)) ? RESP : IDLE;
    ready_d = state_d == RESP;
    err_d = (state_d == RESP) && !legal;
    err_cnt_d = (err_d && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    mem_d = mem_q;
    for (int i = 0; i < NB; i++)
      if (push && i < int'(md.md_size)) mem_d[wptr_q + PW'(i)] = shifted[8*i +: 8];
    wptr_d = push ? wptr_q + PW'(md.md_size) : wptr_q;
    rptr_d = rptr_q + PW'(pop);
    fill_d = fill_q + (push ? LVL_WIDTH'(md.md_size) : '0) - LVL_WIDTH'(pop);
  end
  always_ff @(posedge pclk) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end
  assign md.md_ready = ready_q;
  assign md.md_err = err_q;
  assign out_valid = fill_q != '0;
  assign out_data = mem_q[rptr_q];
  assign fill_level = fill_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_cfs_md_rx_responder.sv
// tb_cfs_md_rx_responder: directed checks of handshake, legality, byte order, back-pressure and reset.
module tb_cfs_md_rx_responder;
  logic pclk, reset, out_ready, out_valid;
  logic [7:0] out_data, err_cnt;
  logic [3:0] fill_level;
  int checks = 0, failures = 0;
  cfs_md_rx_responder_if #(.DATA_WIDTH(32)) md();
  cfs_md_rx_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .pclk(pclk), .reset(reset), .md(md.slave), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fill_level(fill_level), .err_cnt(err_cnt));
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] d, input int off, input int sz);
    md.md_valid = 1'b1;
    md.md_data = d;
    md.md_offset = 2'(off);
    md.md_size = 3'(sz);
  endtask
  task automatic xfer(input logic [31:0] d, input int off, input int sz, input logic e);
    drive(d, off, sz);
    tick();
    chk("xfer_ready", 32'(md.md_ready), 1);
    chk("xfer_err", 32'(md.md_err), 32'(e));
    tick();
    md.md_valid = 1'b0;
    chk("xfer_ready_drop", 32'(md.md_ready), 0);
  endtask
  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    md.md_valid = 1'b0;
    md.md_data = '0;
    md.md_offset = '0;
    md.md_size = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(md.md_ready), 0);
    chk("rst_err", 32'(md.md_err), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    xfer(32'hDDCCBBAA, 0, 4, 1'b0);
    chk("full_fill", 32'(fill_level), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_byte", 32'(out_data), 32'hAA + 32'(i) * 32'h11);
      chk("full_level", 32'(fill_level), 32'(4 - i));
      tick();
    end
    out_ready = 1'b0;
    chk("full_empty", 32'(fill_level), 0);
    chk("full_out_valid", 32'(out_valid), 0);
    xfer(32'h44332211, 1, 2, 1'b0);
    chk("part_fill", 32'(fill_level), 2);
    chk("part_b0", 32'(out_data), 32'h22);
    out_ready = 1'b1;
    tick();
    chk("part_b1", 32'(out_data), 32'h33);
    tick();
    out_ready = 1'b0;
    chk("part_empty", 32'(fill_level), 0);
    xfer(32'h12345678, 3, 2, 1'b1);
    chk("ill_err_cnt1", 32'(err_cnt), 1);
    chk("ill_no_push", 32'(fill_level), 0);
    xfer(32'h12345678, 0, 0, 1'b1);
    chk("ill_err_cnt2", 32'(err_cnt), 2);
    chk("ill_no_push0", 32'(out_valid), 0);
    xfer(32'h03020100, 0, 4, 1'b0);
    xfer(32'h07060504, 0, 4, 1'b0);
    chk("bp_full", 32'(fill_level), 8);
    drive(32'h0B0A0908, 0, 4);
    tick();
    chk("bp_hold", 32'(md.md_ready), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_pop_byte", 32'(out_data), 32'(i));
      tick();
      chk("bp_hold_pop", 32'(md.md_ready), 0);
    end
    out_ready = 1'b0;
    chk("bp_level4", 32'(fill_level), 4);
    tick();
    chk("bp_release", 32'(md.md_ready), 1);
    chk("bp_release_err", 32'(md.md_err), 0);
    tick();
    md.md_valid = 1'b0;
    chk("bp_refill", 32'(fill_level), 8);
    chk("bp_ready_drop", 32'(md.md_ready), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("sim_drain", 32'(out_data), 32'(4 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("sim_level3", 32'(fill_level), 3);
    drive(32'h0F0E0D0C, 0, 4);
    tick();
    chk("sim_ready", 32'(md.md_ready), 1);
    out_ready = 1'b1;
    tick();
    md.md_valid = 1'b0;
    chk("sim_level6", 32'(fill_level), 6);
    for (int i = 0; i < 6; i++) begin
      chk("sim_order", 32'(out_data), 32'(10 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("sim_empty", 32'(fill_level), 0);
    xfer(32'hA3A2A1A0, 0, 4, 1'b0);
    xfer(32'h000000B0, 0, 1, 1'b0);
    chk("rm_level5", 32'(fill_level), 5);
    drive(32'h0000FFFF, 0, 2);
    tick();
    chk("rm_resp", 32'(md.md_ready), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    md.md_valid = 1'b0;
    chk("rm_ready", 32'(md.md_ready), 0);
    chk("rm_err", 32'(md.md_err), 0);
    chk("rm_out_valid", 32'(out_valid), 0);
    chk("rm_fill", 32'(fill_level), 0);
    chk("rm_err_cnt", 32'(err_cnt), 0);
    xfer(32'hC3C2C1C0, 2, 2, 1'b0);
    chk("post_fill", 32'(fill_level), 2);
    chk("post_b0", 32'(out_data), 32'hC2);
    out_ready = 1'b1;
    tick();
    chk("post_b1", 32'(out_data), 32'hC3);
    tick();
    chk("post_empty", 32'(fill_level), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
